// File: rtl/ddr4_phy_v2_2_1_riu_pkg.sv
// Shared types and constants for the XIPHY RIU read-return collector.
package ddr4_phy_v2_2_1_riu_pkg;

  localparam int RIU_DATA_W = 16;

  typedef enum logic {
    RIU_IDLE = 1'b0,
    RIU_WAIT = 1'b1
  } riu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_COLLISION  = 2'd1,
    ERR_UNEXPECTED = 2'd2,
    ERR_WRONG_NIB  = 2'd3
  } riu_err_code_t;

endpackage

// File: rtl/ddr4_phy_v2_2_1_riu_or_stage.sv
// One registered OR level: IN_LANES data/valid lanes fold into OUT_LANES,
// with an unmodified side vector registered alongside. Synchronous clear.
module ddr4_phy_v2_2_1_riu_or_stage
  import ddr4_phy_v2_2_1_riu_pkg::*;
#(
  parameter int IN_LANES  = 2,
  parameter int OUT_LANES = 1,
  parameter int VEC_W     = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [IN_LANES*RIU_DATA_W-1:0]  data_in,
  input  logic [IN_LANES-1:0]             vld_in,
  input  logic [VEC_W-1:0]                vec_in,
  output logic [OUT_LANES*RIU_DATA_W-1:0] data_out,
  output logic [OUT_LANES-1:0]            vld_out,
  output logic [VEC_W-1:0]                vec_out
);

  localparam int GROUP = IN_LANES / OUT_LANES;

  if (OUT_LANES < 1 || (IN_LANES % OUT_LANES) != 0) begin : g_bad_lanes
    $error("riu_or_stage: IN_LANES must be a multiple of OUT_LANES");
  end

  logic [OUT_LANES*RIU_DATA_W-1:0] data_d, data_q;
  logic [OUT_LANES-1:0]            vld_d,  vld_q;
  logic [VEC_W-1:0]                vec_d,  vec_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data_d = '0;
    vld_d  = '0;
    vec_d  = vec_in;
    for (int o = 0; o < OUT_LANES; o++) begin
      for (int g = 0; g < GROUP; g++) begin
        data_d[o*RIU_DATA_W +: RIU_DATA_W] = data_d[o*RIU_DATA_W +: RIU_DATA_W]
                                           | data_in[(o*GROUP+g)*RIU_DATA_W +: RIU_DATA_W];
        vld_d[o] = vld_d[o] | vld_in[o*GROUP+g];
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= '0;
      vec_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      vec_q  <= vec_d;
    end
  end

  assign data_out = data_q;
  assign vld_out  = vld_q;
  assign vec_out  = vec_q;

endmodule

// File: rtl/ddr4_phy_v2_2_1_riu_rd_collector.sv
// RIU read-return collector: two-level registered OR tree plus a read tracker.
// Define RIU_RD_TIMEOUT_EN to build the WAIT-state timeout counter.
module ddr4_phy_v2_2_1_riu_rd_collector
  import ddr4_phy_v2_2_1_riu_pkg::*;
#(
  parameter int NIBBLES     = 8,
  parameter int TIMEOUT_CYC = 63
) (
  input  logic                          riu_clk,
  input  logic                          riu_rst,
  input  logic [NIBBLES*RIU_DATA_W-1:0] riu_rd_data_nib,
  input  logic [NIBBLES-1:0]            riu_valid_nib,
  input  logic                          riu_rd_req,
  input  logic [$clog2(NIBBLES)-1:0]    riu_rd_nib_sel,
  output logic [RIU_DATA_W-1:0]         riu_rd_data,
  output logic                          riu_valid,
  output logic                          riu_rd_done,
  output logic                          riu_rd_timeout,
  output logic                          riu_rd_err,
  output logic [1:0]                    riu_rd_err_code,
  output logic                          riu_rd_busy
);

  localparam int SEL_W = $clog2(NIBBLES);
  localparam int PAIRS = NIBBLES / 2;
  localparam logic [NIBBLES-1:0] VEC_ONE = {{(NIBBLES-1){1'b0}}, 1'b1};

  if (NIBBLES < 2 || NIBBLES > 16 || (NIBBLES % 2) != 0) begin : g_bad_nibbles
    $error("riu_rd_collector: NIBBLES must be even and within 2..16");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_timeout
    $error("riu_rd_collector: TIMEOUT_CYC must be within 1..1023");
  end

  logic [PAIRS*RIU_DATA_W-1:0] data1;
  logic [PAIRS-1:0]            vld1;
  logic [NIBBLES-1:0]          vvec1;
  logic [RIU_DATA_W-1:0]       data2;
  logic [0:0]                  vld2;
  logic [NIBBLES-1:0]          vvec2;

  ddr4_phy_v2_2_1_riu_or_stage #(
    .IN_LANES (NIBBLES),
    .OUT_LANES(PAIRS),
    .VEC_W    (NIBBLES)
  ) u_stage1 (
    .clk     (riu_clk),
    .rst     (riu_rst),
    .data_in (riu_rd_data_nib),
    .vld_in  (riu_valid_nib),
    .vec_in  (riu_valid_nib),
    .data_out(data1),
    .vld_out (vld1),
    .vec_out (vvec1)
  );

  ddr4_phy_v2_2_1_riu_or_stage #(
    .IN_LANES (PAIRS),
    .OUT_LANES(1),
    .VEC_W    (NIBBLES)
  ) u_stage2 (
    .clk     (riu_clk),
    .rst     (riu_rst),
    .data_in (data1),
    .vld_in  (vld1),
    .vec_in  (vvec1),
    .data_out(data2),
    .vld_out (vld2),
    .vec_out (vvec2)
  );

  assign riu_rd_data = data2;
  assign riu_valid   = vld2[0];

  riu_state_t    state_q, state_d;
  logic [SEL_W-1:0] exp_nib_q, exp_nib_d;
  riu_err_code_t err_code_q, err_code_d;
  riu_err_code_t new_code;
  logic [NIBBLES-1:0] exp_onehot;
  logic collide;
  logic done;
  logic err;
  logic accept;
  logic to_hit;

`ifdef RIU_RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] count_q, count_d;

  // A return landing on the limit cycle completes the read instead of timing out.
  assign to_hit = (state_q == RIU_WAIT) && !riu_valid && (count_q == CNT_MAX);

  always_comb begin
    count_d = count_q;
    if (accept) begin
      count_d = '0;
    end else if (state_q == RIU_WAIT) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge riu_clk) begin
    if (riu_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    exp_nib_d  = exp_nib_q;
    err_code_d = err_code_q;
    new_code   = ERR_NONE;
    done       = 1'b0;
    err        = 1'b0;
    accept     = 1'b0;
    exp_onehot = VEC_ONE << exp_nib_q;
    collide    = |(vvec2 & (vvec2 - VEC_ONE));

    // Any return seen in WAIT consumes the outstanding read, good or bad.
    if (riu_valid) begin
      if (collide) begin
        err      = 1'b1;
        new_code = ERR_COLLISION;
      end else if (state_q == RIU_WAIT) begin
        if (vvec2 == exp_onehot) begin
          done = 1'b1;
        end else begin
          err      = 1'b1;
          new_code = ERR_WRONG_NIB;
        end
      end else begin
        err      = 1'b1;
        new_code = ERR_UNEXPECTED;
      end
      if (state_q == RIU_WAIT) begin
        state_d = RIU_IDLE;
      end
    end else if (to_hit) begin
      state_d = RIU_IDLE;
    end

    // A request is accepted whenever the tracker is free after this cycle's retirement.
    if (riu_rd_req) begin
      if (state_d == RIU_IDLE) begin
        accept    = 1'b1;
        state_d   = RIU_WAIT;
        exp_nib_d = riu_rd_nib_sel;
      end else begin
        err      = 1'b1;
        new_code = ERR_UNEXPECTED;
      end
    end

    // An error reported in the same cycle as an acceptance stays visible.
    if (accept) begin
      err_code_d = ERR_NONE;
    end
    if (err) begin
      err_code_d = new_code;
    end
  end

  always_ff @(posedge riu_clk) begin
    if (riu_rst) begin
      state_q    <= RIU_IDLE;
      exp_nib_q  <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      exp_nib_q  <= exp_nib_d;
      err_code_q <= err_code_d;
    end
  end

  assign riu_rd_done     = done;
  assign riu_rd_err      = err;
  assign riu_rd_timeout  = to_hit;
  assign riu_rd_err_code = err_code_q;
  assign riu_rd_busy     = (state_q == RIU_WAIT);

endmodule

// File: tb/tb_ddr4_phy_v2_2_1_riu_rd_collector.sv
// Directed bench for the RIU read-return collector (NIBBLES = 8).
module tb_ddr4_phy_v2_2_1_riu_rd_collector;

  localparam int NIB = 8;
`ifdef RIU_RD_TIMEOUT_EN
  localparam int TO  = 4;
  localparam int GAP = 1;
`else
  localparam int TO  = 63;
  localparam int GAP = 5;
`endif

  logic              riu_clk = 1'b0;
  logic              riu_rst;
  logic [NIB*16-1:0] riu_rd_data_nib;
  logic [NIB-1:0]    riu_valid_nib;
  logic              riu_rd_req;
  logic [2:0]        riu_rd_nib_sel;
  logic [15:0]       riu_rd_data;
  logic              riu_valid;
  logic              riu_rd_done;
  logic              riu_rd_timeout;
  logic              riu_rd_err;
  logic [1:0]        riu_rd_err_code;
  logic              riu_rd_busy;

  int n_vec  = 0;
  int n_miss = 0;

  ddr4_phy_v2_2_1_riu_rd_collector #(
    .NIBBLES    (NIB),
    .TIMEOUT_CYC(TO)
  ) dut (
    .riu_clk        (riu_clk),
    .riu_rst        (riu_rst),
    .riu_rd_data_nib(riu_rd_data_nib),
    .riu_valid_nib  (riu_valid_nib),
    .riu_rd_req     (riu_rd_req),
    .riu_rd_nib_sel (riu_rd_nib_sel),
    .riu_rd_data    (riu_rd_data),
    .riu_valid      (riu_valid),
    .riu_rd_done    (riu_rd_done),
    .riu_rd_timeout (riu_rd_timeout),
    .riu_rd_err     (riu_rd_err),
    .riu_rd_err_code(riu_rd_err_code),
    .riu_rd_busy    (riu_rd_busy)
  );

  always #5 riu_clk = ~riu_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge riu_clk);
    #1;
  endtask

  task automatic clear_inputs();
    riu_rd_data_nib = '0;
    riu_valid_nib   = '0;
    riu_rd_req      = 1'b0;
    riu_rd_nib_sel  = '0;
  endtask

  task automatic drive_nib(input int n, input logic [15:0] d);
    riu_rd_data_nib[n*16 +: 16] = d;
    riu_valid_nib[n]            = 1'b1;
  endtask

  task automatic request(input logic [2:0] sel);
    riu_rd_req     = 1'b1;
    riu_rd_nib_sel = sel;
  endtask

  initial begin
    clear_inputs();
    riu_rst = 1'b1;
    repeat (3) step();
    riu_rst = 1'b0;
    check("rst_data",  riu_rd_data, 16'h0000);
    check("rst_valid", riu_valid, 0);
    check("rst_busy",  riu_rd_busy, 0);
    check("rst_code",  riu_rd_err_code, 0);
    check("rst_done",  riu_rd_done, 0);
    check("rst_err",   riu_rd_err, 0);
    check("rst_to",    riu_rd_timeout, 0);

    // Return on the expected nibble 3.
    request(3'd3);
    step();
    clear_inputs();
    check("t1_busy_rise", riu_rd_busy, 1);
    repeat (GAP - 1) step();
    drive_nib(3, 16'hA5C3);
    step();
    clear_inputs();
    step();
    check("t1_valid", riu_valid, 1);
    check("t1_data",  riu_rd_data, 16'hA5C3);
    check("t1_done",  riu_rd_done, 1);
    check("t1_err",   riu_rd_err, 0);
    step();
    check("t1_busy_fall", riu_rd_busy, 0);
    check("t1_done_pulse", riu_rd_done, 0);

    // Collision on nibbles 1 and 3 while nibble 3 is outstanding.
    request(3'd3);
    step();
    clear_inputs();
    drive_nib(1, 16'h00F0);
    drive_nib(3, 16'h0F00);
    step();
    clear_inputs();
    step();
    check("t2_col_data", riu_rd_data, 16'h0FF0);
    check("t2_col_err",  riu_rd_err, 1);
    check("t2_col_done", riu_rd_done, 0);
    step();
    check("t2_col_code", riu_rd_err_code, 1);
    check("t2_col_idle", riu_rd_busy, 0);

    // Wrong nibble: read to nibble 0, return on nibble 2.
    request(3'd0);
    step();
    clear_inputs();
    check("t2_code_clr", riu_rd_err_code, 0);
    drive_nib(2, 16'h1234);
    step();
    clear_inputs();
    step();
    check("t2_wn_err",  riu_rd_err, 1);
    check("t2_wn_done", riu_rd_done, 0);
    step();
    check("t2_wn_code", riu_rd_err_code, 3);
    check("t2_wn_idle", riu_rd_busy, 0);

    // Unexpected return in IDLE still passes through.
    drive_nib(6, 16'hBEEF);
    step();
    clear_inputs();
    step();
    check("t3_valid", riu_valid, 1);
    check("t3_data",  riu_rd_data, 16'hBEEF);
    check("t3_err",   riu_rd_err, 1);
    step();
    check("t3_code",  riu_rd_err_code, 2);

`ifdef RIU_RD_TIMEOUT_EN
    // No return: timeout fires in the fifth busy cycle (count 0..4).
    request(3'd5);
    step();
    clear_inputs();
    for (int i = 0; i < TO; i++) begin
      check("t4_no_to", riu_rd_timeout, 0);
      step();
    end
    check("t4_to",      riu_rd_timeout, 1);
    check("t4_to_busy", riu_rd_busy, 1);
    step();
    check("t4_to_idle", riu_rd_busy, 0);
    check("t4_to_code", riu_rd_err_code, 0);

    // Return lands on the limit cycle: done wins over timeout.
    request(3'd5);
    step();
    clear_inputs();
    step();
    step();
    drive_nib(5, 16'h5555);
    step();
    clear_inputs();
    step();
    check("t4_al_done", riu_rd_done, 1);
    check("t4_al_to",   riu_rd_timeout, 0);
    step();
    check("t4_al_idle", riu_rd_busy, 0);
`else
    // Without the timeout a read waits indefinitely.
    request(3'd5);
    step();
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      check("t4_no_to", riu_rd_timeout, 0);
      step();
    end
    check("t4_still_busy", riu_rd_busy, 1);
    drive_nib(5, 16'h5555);
    step();
    clear_inputs();
    step();
    check("t4_late_done", riu_rd_done, 1);
    step();
    check("t4_late_idle", riu_rd_busy, 0);
`endif

    // Back-to-back: completion and new request in the same cycle.
    request(3'd2);
    step();
    clear_inputs();
    drive_nib(2, 16'h0002);
    step();
    clear_inputs();
    step();
    request(3'd7);
    #1;
    check("t5_done1", riu_rd_done, 1);
    check("t5_noerr", riu_rd_err, 0);
    step();
    clear_inputs();
    check("t5_busy",  riu_rd_busy, 1);
    check("t5_code",  riu_rd_err_code, 0);
    drive_nib(7, 16'h7777);
    step();
    clear_inputs();
    step();
    check("t5_done2", riu_rd_done, 1);
    check("t5_data2", riu_rd_data, 16'h7777);
    step();
    check("t5_idle",  riu_rd_busy, 0);

    // Dropped request in WAIT, then reset with a return in flight.
    request(3'd1);
    step();
    clear_inputs();
    request(3'd4);
    #1;
    check("t6_drop_err", riu_rd_err, 1);
    step();
    clear_inputs();
    check("t6_drop_code", riu_rd_err_code, 2);
    check("t6_drop_busy", riu_rd_busy, 1);
    drive_nib(1, 16'h1111);
    step();
    clear_inputs();
    riu_rst = 1'b1;
    step();
    riu_rst = 1'b0;
    check("t6_rst_data", riu_rd_data, 16'h0000);
    check("t6_rst_busy", riu_rd_busy, 0);
    check("t6_rst_code", riu_rd_err_code, 0);
    check("t6_rst_done", riu_rd_done, 0);
    check("t6_rst_err",  riu_rd_err, 0);
    step();
    check("t6_flush", riu_valid, 0);
    drive_nib(1, 16'h2222);
    step();
    clear_inputs();
    step();
    check("t6_late_err",  riu_rd_err, 1);
    check("t6_late_done", riu_rd_done, 0);
    step();
    check("t6_late_code", riu_rd_err_code, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
